// File: rtl/e_mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
//   MDU_* opcodes carried on the 4-bit Op bus, default latencies,
//   the {hi,lo} result payload and the sequencer state encoding.
package e_mdu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;

  localparam logic [OP_W-1:0] MDU_NONE  = 4'd0;
  localparam logic [OP_W-1:0] MDU_MULT  = 4'd1;
  localparam logic [OP_W-1:0] MDU_MULTU = 4'd2;
  localparam logic [OP_W-1:0] MDU_DIV   = 4'd3;
  localparam logic [OP_W-1:0] MDU_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] MDU_MTHI  = 4'd5;
  localparam logic [OP_W-1:0] MDU_MTLO  = 4'd6;
  localparam logic [OP_W-1:0] MDU_MFHI  = 4'd7;
  localparam logic [OP_W-1:0] MDU_MFLO  = 4'd8;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  // 64-bit result as written to {HI,LO}
  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } hilo_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  function automatic logic is_mult(input logic [OP_W-1:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational multiply/divide datapath.
//   op       : MDU opcode
//   a, b     : rs / rt operands
//   res      : {hi,lo} result (mult: product; div: {remainder,quotient})
//   div_zero : op is div/divu and b is zero
module e_mdu_calc
  import e_mdu_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output hilo_t             res,
  output logic              div_zero
);

  logic [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0] prod_u;
  logic                a_neg;
  logic                b_neg;
  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W-1:0]   b_mag;
  logic [DATA_W-1:0]   q_mag;
  logic [DATA_W-1:0]   r_mag;
  logic [DATA_W-1:0]   q_u;
  logic [DATA_W-1:0]   r_u;
  logic                b_zero;

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000.
  always_comb begin
    prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    prod_s = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
    a_neg  = a[DATA_W-1];
    b_neg  = b[DATA_W-1];
    a_mag  = a_neg ? (~a + DATA_W'(1)) : a;
    b_mag  = b_neg ? (~b + DATA_W'(1)) : b;
    b_zero = (b == '0);
    q_mag  = '0;
    r_mag  = '0;
    q_u    = '0;
    r_u    = '0;
    if (!b_zero) begin
      q_u   = a / b;
      r_u   = a % b;
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
  end

  always_comb begin
    res      = '0;
    div_zero = 1'b0;
    case (op)
      MDU_MULT:  res = hilo_t'(prod_s);
      MDU_MULTU: res = hilo_t'(prod_u);
      MDU_DIV: begin
        res.lo   = (a_neg ^ b_neg) ? (~q_mag + DATA_W'(1)) : q_mag;
        res.hi   = a_neg ? (~r_mag + DATA_W'(1)) : r_mag;
        div_zero = b_zero;
      end
      MDU_DIVU: begin
        res.lo   = q_u;
        res.hi   = r_u;
        div_zero = b_zero;
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit; owns architectural HI/LO.
//   Clk, Rst(async, active-low)
//   Start, Op, A, B : operation qualifier, MDU opcode, rs/rt operands
//   Busy            : mult/div in flight (hazard unit stalls on it)
//   HI, LO          : architectural registers
//   HILO_out        : HI for mfhi, LO for mflo, else 0 (combinational from Op)
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [OP_W-1:0]   Op,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              Busy,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO,
  output logic [DATA_W-1:0] HILO_out
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  hilo_t             pend_q, pend_d;
  logic              pend_dz_q, pend_dz_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  hilo_t             calc_res;
  logic              calc_dz;

  e_mdu_calc u_calc (
    .op       (Op),
    .a        (A),
    .b        (B),
    .res      (calc_res),
    .div_zero (calc_dz)
  );

  // State and architectural registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_dz_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_dz_q <= pend_dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Sequencer: result is computed at issue, held in pending regs, committed when the count expires
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_dz_d = pend_dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if (is_muldiv(Op)) begin
            pend_d    = calc_res;
            pend_dz_d = calc_dz;
            cnt_d     = is_mult(Op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            state_d   = ST_RUN;
          end else if (Op == MDU_MTHI) begin
            hi_d = A;
          end else if (Op == MDU_MTLO) begin
            lo_d = A;
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          // Divide by zero burns the latency but leaves HI/LO alone
          if (!pend_dz_q) begin
            hi_d = pend_q.hi;
            lo_d = pend_q.lo;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read port deliberately sees only the registered HI/LO
  always_comb begin
    HILO_out = '0;
    if (Op == MDU_MFHI) begin
      HILO_out = hi_q;
    end else if (Op == MDU_MFLO) begin
      HILO_out = lo_q;
    end
  end

  assign Busy = (state_q == ST_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: a driver issues directed and random operations and
// pushes expected results computed with plain integer arithmetic; a monitor pops
// and compares whenever Busy falls (mult/div commit) or Op presents an mf read.
module tb_e_mdu;
  import e_mdu_pkg::*;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        Clk   = 1'b0;
  logic        Rst   = 1'b0;
  logic        Start = 1'b0;
  logic [3:0]  Op    = MDU_NONE;
  logic [31:0] A     = '0;
  logic [31:0] B     = '0;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] HILO_out;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t        res_q[$];
  logic [31:0] mf_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  int   mon_len  = 0;
  logic mon_prev = 1'b0;

  always #5 Clk = ~Clk;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Start    (Start),
    .Op       (Op),
    .A        (A),
    .B        (B),
    .Busy     (Busy),
    .HI       (HI),
    .LO       (LO),
    .HILO_out (HILO_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: architectural result of one operation given the current HI/LO
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] hi, input logic [31:0] lo);
    exp_t                  e;
    longint                sa, sb, q, r;
    longint unsigned       ua, ub, uq, ur;
    logic [63:0]           pr;
    e.hi  = hi;
    e.lo  = lo;
    e.len = (op == MDU_MULT || op == MDU_MULTU) ? int'(MC) : int'(DC);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MDU_MULT: begin
        pr = 64'(sa * sb);
        e.hi = pr[63:32];
        e.lo = pr[31:0];
      end
      MDU_MULTU: begin
        pr = 64'(ua * ub);
        e.hi = pr[63:32];
        e.lo = pr[31:0];
      end
      MDU_DIV: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        e.lo = q[31:0];
        e.hi = r[31:0];
      end
      MDU_DIVU: if (b != 0) begin
        uq = ua / ub;
        ur = ua % ub;
        e.lo = uq[31:0];
        e.hi = ur[31:0];
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = s;
    Op    = op;
    A     = a;
    B     = b;
    tick();
    Start = 1'b0;
    Op    = MDU_NONE;
    A     = $urandom();
    B     = $urandom();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (Busy && n < 100) begin
      tick();
      n++;
    end
    if (Busy) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout actual=busy required=idle");
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    if (op == MDU_MULT || op == MDU_MULTU || op == MDU_DIV || op == MDU_DIVU) begin
      e = model(op, a, b, m_hi, m_lo);
      m_hi = e.hi;
      m_lo = e.lo;
      res_q.push_back(e);
      drive(1'b1, op, a, b);
      wait_idle();
    end else if (op == MDU_MTHI) begin
      m_hi = a;
      drive(1'b1, op, a, b);
    end else if (op == MDU_MTLO) begin
      m_lo = a;
      drive(1'b1, op, a, b);
    end else if (op == MDU_MFHI) begin
      mf_q.push_back(m_hi);
      drive(1'($urandom_range(0, 1)), op, a, b);
    end else if (op == MDU_MFLO) begin
      mf_q.push_back(m_lo);
      drive(1'($urandom_range(0, 1)), op, a, b);
    end else begin
      drive(1'b1, op, a, b);
    end
  endtask

  // Monitor: commit checks on Busy falling, read-port checks every cycle
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clk);
      if (!Rst) begin
        mon_len  = 0;
        mon_prev = 1'b0;
      end else begin
        if (Busy) begin
          mon_len++;
        end else if (mon_prev) begin
          if (res_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_commit actual=HI:%h/LO:%h required=no_commit", HI, LO);
          end else begin
            e = res_q.pop_front();
            chk("busy_len", 32'(mon_len), 32'(e.len));
            chk("commit_hi", HI, e.hi);
            chk("commit_lo", LO, e.lo);
          end
          mon_len = 0;
        end
        mon_prev = Busy;
        if (Op == MDU_MFHI || Op == MDU_MFLO) begin
          if (mf_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL mf_unexpected actual=%h required=queued_read", HILO_out);
          end else begin
            chk("hilo_out_mf", HILO_out, mf_q.pop_front());
          end
        end else begin
          chk("hilo_out_idle", HILO_out, 32'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    exp_t        e;
    logic [3:0]  op;
    logic [31:0] a, b;

    // Reset state
    tick();
    tick();
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    Rst = 1'b1;
    tick();

    // Reset in the middle of a mult aborts it with no later commit
    issue(MDU_MTHI, 32'h11, 32'h0);
    issue(MDU_MTLO, 32'h22, 32'h0);
    drive(1'b1, MDU_MULT, 32'h1234, 32'h5678);
    tick();
    chk("run_busy", 32'(Busy), 32'd1);
    #2 Rst = 1'b0;
    #1;
    chk("async_rst_busy", 32'(Busy), 32'd0);
    chk("async_rst_hi", HI, 32'd0);
    chk("async_rst_lo", LO, 32'd0);
    m_hi = '0;
    m_lo = '0;
    tick();
    Rst = 1'b1;
    repeat (8) tick();
    chk("post_rst_hi", HI, 32'd0);
    chk("post_rst_lo", LO, 32'd0);
    chk("post_rst_busy", 32'(Busy), 32'd0);

    // Directed mult/multu
    issue(MDU_MULT, 32'hFFFFFFFE, 32'd3);
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFFA);
    issue(MDU_MULTU, 32'hFFFFFFFE, 32'd3);
    chk("multu_hi", HI, 32'h00000002);
    chk("multu_lo", LO, 32'hFFFFFFFA);

    // Directed div/divu
    issue(MDU_DIV, 32'hFFFFFFF9, 32'd2);
    chk("div_lo", LO, 32'hFFFFFFFD);
    chk("div_hi", HI, 32'hFFFFFFFF);
    issue(MDU_DIVU, 32'd7, 32'd2);
    chk("divu_lo", LO, 32'd3);
    chk("divu_hi", HI, 32'd1);

    // mthi then mfhi in the next cycle
    issue(MDU_MTHI, 32'h12345678, 32'h0);
    issue(MDU_MFHI, 32'h0, 32'h0);
    chk("mt_no_busy", 32'(Busy), 32'd0);

    // Divide by zero keeps HI/LO; most-negative over -1 wraps
    issue(MDU_MTLO, 32'hAA, 32'h0);
    issue(MDU_MTHI, 32'hBB, 32'h0);
    issue(MDU_DIV, 32'd5, 32'd0);
    chk("divz_lo", LO, 32'hAA);
    chk("divz_hi", HI, 32'hBB);
    issue(MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
    chk("divovf_lo", LO, 32'h80000000);
    chk("divovf_hi", HI, 32'h0);

    // Start and mtlo while busy are ignored; first result lands on schedule
    e = model(MDU_MULT, 32'd3, 32'd4, m_hi, m_lo);
    m_hi = e.hi;
    m_lo = e.lo;
    res_q.push_back(e);
    drive(1'b1, MDU_MULT, 32'd3, 32'd4);
    tick();
    drive(1'b1, MDU_MULT, 32'd7, 32'd9);
    drive(1'b1, MDU_MTLO, 32'h55, 32'h0);
    wait_idle();
    chk("busy_ignore_lo", LO, 32'd12);
    chk("busy_ignore_hi", HI, 32'd0);

    // Randomized operations against the reference model
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0: op = MDU_MULT;
        1: op = MDU_MULTU;
        2: op = MDU_DIV;
        3: op = MDU_DIVU;
        4: op = MDU_MTHI;
        5: op = MDU_MTLO;
        6: op = MDU_MFHI;
        default: op = MDU_MFLO;
      endcase
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin a = 32'($urandom_range(0, 40)) - 32'd20; b = 32'($urandom_range(0, 10)) - 32'd5; end
        default: ;
      endcase
      issue(op, a, b);
      if ($urandom_range(0, 2) == 0) issue(($urandom_range(0, 1) == 0) ? MDU_MFHI : MDU_MFLO, 32'h0, 32'h0);
    end

    repeat (3) tick();
    chk("res_drain", 32'(res_q.size()), 32'd0);
    chk("mf_drain", 32'(mf_q.size()), 32'd0);
    chk("final_hi", HI, m_hi);
    chk("final_lo", LO, m_lo);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
